// File: rtl/drac_arb_pkg.sv
// Shared definitions for the DDR3 user-port arbiter: bus widths, FSM encoding
// and the same-owner burst counter update.
package drac_arb_pkg;

    localparam int SA_MSB = 33;
    localparam int SA_LSB = 5;
    localparam int DW     = 256;
    localparam int MW     = 32;
    localparam int CW     = 4;

    localparam logic [CW-1:0] CNT_MAX = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // A new owner starts its burst at 1; a repeat grant counts up and saturates.
    function automatic logic [CW-1:0] cnt_next(input logic same_owner,
                                               input logic [CW-1:0] cnt);
        logic [CW-1:0] nxt;
        nxt = 4'd1;
        if (same_owner) begin
            nxt = (cnt == CNT_MAX) ? CNT_MAX : cnt + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/drac_arb_if.sv
// One DDR3 user-port style link: request/address/data/mask from the master,
// read data and completion strobe back from the slave.
interface drac_arb_if;

    logic                                              rd;
    logic                                              wr;
    logic [drac_arb_pkg::SA_MSB:drac_arb_pkg::SA_LSB]  a;
    logic [drac_arb_pkg::DW-1:0]                       wdat;
    logic [drac_arb_pkg::MW-1:0]                       msk;
    logic [drac_arb_pkg::DW-1:0]                       rdat;
    logic                                              rdy;

    modport master (
        output rd, wr, a, wdat, msk,
        input  rdat, rdy
    );

    modport slave (
        input  rd, wr, a, wdat, msk,
        output rdat, rdy
    );

endinterface

// File: rtl/drac_arb_pick.sv
// Combinational two-way pick: a lone requester always wins; on a tie the
// current owner keeps the port until its burst count reaches BURST.
module drac_arb_pick
    import drac_arb_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic          i_req0,
    input  logic          i_req1,
    input  logic          i_owner,
    input  logic [CW-1:0] i_cnt,
    output logic          o_gnt_valid,
    output logic          o_gnt_port
);

    localparam logic [CW-1:0] BURST_C = CW'(BURST);

    always_comb begin
        o_gnt_valid = i_req0 | i_req1;
        o_gnt_port  = 1'b0;
        if (i_req0 && i_req1) begin
            o_gnt_port = (i_cnt < BURST_C) ? i_owner : ~i_owner;
        end else if (i_req1) begin
            o_gnt_port = 1'b1;
        end
    end

endmodule

// File: rtl/drac_arb.sv
// Two-requester arbiter in front of the drac_ddr3 user port: one transaction
// at a time, registered downstream request, completion steered to the owner.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no transaction; pick a requester and load the downstream
//   ST_ISSUE | downstream request held until srdy
//   ST_GAP   | one dead cycle after completion; requests ignored
module drac_arb
    import drac_arb_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic        ckdr,
    input  logic        reset,
    drac_arb_if.slave   m0,
    drac_arb_if.slave   m1,
    drac_arb_if.master  s,
    output logic        busy,
    output logic        owner,
    output logic        proto_err
);

    localparam logic [CW-1:0] BURST_C = CW'(BURST);

    state_t                r_state;
    logic                  r_owner;
    logic [CW-1:0]         r_cnt;
    logic                  r_srd;
    logic                  r_swr;
    logic [SA_MSB:SA_LSB]  r_sa;
    logic [DW-1:0]         r_swdat;
    logic [MW-1:0]         r_smsk;
    logic                  r_err;

    logic                  w_req0;
    logic                  w_req1;
    logic                  w_gnt_valid;
    logic                  w_gnt_port;
    logic                  w_sel_rd;
    logic                  w_sel_wr;
    logic [SA_MSB:SA_LSB]  w_sel_a;
    logic [DW-1:0]         w_sel_wdat;
    logic [MW-1:0]         w_sel_msk;

    assign w_req0 = m0.rd | m0.wr;
    assign w_req1 = m1.rd | m1.wr;

    drac_arb_pick #(
        .BURST (BURST)
    ) u_pick (
        .i_req0      (w_req0),
        .i_req1      (w_req1),
        .i_owner     (r_owner),
        .i_cnt       (r_cnt),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_port  (w_gnt_port)
    );

    assign w_sel_rd   = w_gnt_port ? m1.rd   : m0.rd;
    assign w_sel_wr   = w_gnt_port ? m1.wr   : m0.wr;
    assign w_sel_a    = w_gnt_port ? m1.a    : m0.a;
    assign w_sel_wdat = w_gnt_port ? m1.wdat : m0.wdat;
    assign w_sel_msk  = w_gnt_port ? m1.msk  : m0.msk;

    always_ff @(posedge ckdr or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b1;
            r_cnt   <= BURST_C;
            r_srd   <= 1'b0;
            r_swr   <= 1'b0;
            r_sa    <= '0;
            r_swdat <= '0;
            r_smsk  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s.rdy) begin
                        r_err <= 1'b1;
                    end
                    if (w_gnt_valid) begin
                        r_sa    <= w_sel_a;
                        r_swdat <= w_sel_wdat;
                        r_smsk  <= w_sel_msk;
                        // rd and wr together is a contract breach: issue as a read
                        r_srd   <= w_sel_rd;
                        r_swr   <= w_sel_wr & ~w_sel_rd;
                        if (w_sel_rd && w_sel_wr) begin
                            r_err <= 1'b1;
                        end
                        r_owner <= w_gnt_port;
                        r_cnt   <= cnt_next(w_gnt_port == r_owner, r_cnt);
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (s.rdy) begin
                        r_srd   <= 1'b0;
                        r_swr   <= 1'b0;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (s.rdy) begin
                        r_err <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_srd   <= 1'b0;
                    r_swr   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s.rd    = r_srd;
    assign s.wr    = r_swr;
    assign s.a     = r_sa;
    assign s.wdat  = r_swdat;
    assign s.msk   = r_smsk;

    // Read data is broadcast; only the strobe identifies the owner.
    assign m0.rdat = s.rdat;
    assign m1.rdat = s.rdat;
    assign m0.rdy  = s.rdy & (r_state == ST_ISSUE) & ~r_owner;
    assign m1.rdy  = s.rdy & (r_state == ST_ISSUE) &  r_owner;

    assign busy      = (r_state != ST_IDLE);
    assign owner     = r_owner;
    assign proto_err = r_err;

endmodule

// File: tb/tb_drac_arb.sv
// Self-checking bench for drac_arb: a scoreboard of expected downstream
// transactions, a table of single-transaction cases and hand-written sequences.
module tb_drac_arb;
    import drac_arb_pkg::*;

    logic ckdr = 1'b0;
    logic reset;
    logic busy, owner, proto_err;

    drac_arb_if m0_if ();
    drac_arb_if m1_if ();
    drac_arb_if s_if ();

    drac_arb #(.BURST(4)) dut (
        .ckdr      (ckdr),
        .reset     (reset),
        .m0        (m0_if),
        .m1        (m1_if),
        .s         (s_if),
        .busy      (busy),
        .owner     (owner),
        .proto_err (proto_err)
    );

    always #5 ckdr = ~ckdr;

    typedef struct {
        logic         port;
        logic         rd;
        logic         wr;
        logic [28:0]  a;
        logic [255:0] wdat;
        logic [31:0]  msk;
    } exp_t;

    typedef struct {
        logic rd0, wr0, rd1, wr1;
        logic port, erd, ewr, eerr;
    } row_t;

    exp_t sb[$];
    int   rem[2];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   rdy0_cnt = 0;
    int   rdy1_cnt = 0;

    always @(negedge ckdr) begin
        if (m0_if.rdy === 1'b1) rdy0_cnt++;
        if (m1_if.rdy === 1'b1) rdy1_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ckdr);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event did not occur", nm);
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive(input int p, input logic rd, input logic wr, input logic [28:0] a,
                         input logic [255:0] wd, input logic [31:0] mk);
        if (p == 0) begin
            m0_if.rd = rd; m0_if.wr = wr; m0_if.a = a; m0_if.wdat = wd; m0_if.msk = mk;
        end else begin
            m1_if.rd = rd; m1_if.wr = wr; m1_if.a = a; m1_if.wdat = wd; m1_if.msk = mk;
        end
    endtask

    task automatic push(input logic p, input logic rd, input logic wr, input logic [28:0] a,
                        input logic [255:0] wd, input logic [31:0] mk);
        exp_t e;
        e.port = p; e.rd = rd; e.wr = wr; e.a = a; e.wdat = wd; e.msk = mk;
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #2;
        tick();
        reset = 1'b0;
    endtask

    // Requester after its completion: next line address, or drop when done.
    task automatic requester_done(input logic p);
        if (p == 1'b0) begin
            rem[0]--;
            if (rem[0] <= 0) begin
                m0_if.rd = 1'b0; m0_if.wr = 1'b0;
            end else begin
                m0_if.a = m0_if.a + 29'd1; m0_if.wdat = m0_if.wdat + 256'd1;
            end
        end else begin
            rem[1]--;
            if (rem[1] <= 0) begin
                m1_if.rd = 1'b0; m1_if.wr = 1'b0;
            end else begin
                m1_if.a = m1_if.a + 29'd1; m1_if.wdat = m1_if.wdat + 256'd1;
            end
        end
    endtask

    // Controller model: wait for a downstream request, check it against the
    // scoreboard, answer after lat cycles, check steering and the GAP cycle.
    task automatic serve(input int lat, input int exp_wait);
        int           w;
        exp_t         e;
        logic [255:0] rdat;
        w = 0;
        while (!(s_if.rd | s_if.wr) && w < 20) begin
            tick();
            w++;
        end
        if (!(s_if.rd | s_if.wr)) begin
            fail_now("issue_timeout");
            return;
        end
        if (exp_wait >= 0) chk("grant_latency", w, exp_wait);
        if (sb.size() == 0) begin
            fail_now("scoreboard_underflow");
            return;
        end
        e = sb.pop_front();
        chk("srd", s_if.rd, e.rd);
        chk("swr", s_if.wr, e.wr);
        chk("sa", s_if.a, e.a);
        chk("swdat", s_if.wdat, e.wdat);
        chk("smsk", s_if.msk, e.msk);
        chk("owner", owner, e.port);
        chk("busy_issue", busy, 1'b1);
        for (int i = 0; i < lat; i++) begin
            tick();
            chk("hold_srd", s_if.rd, e.rd);
            chk("no_early_rdy", m0_if.rdy | m1_if.rdy, 1'b0);
        end
        rdat = rnd256();
        s_if.rdat = rdat;
        s_if.rdy  = 1'b1;
        #1;
        chk("m0_rdy", m0_if.rdy, e.port == 1'b0);
        chk("m1_rdy", m1_if.rdy, e.port == 1'b1);
        chk("m0_rdat", m0_if.rdat, rdat);
        chk("m1_rdat", m1_if.rdat, rdat);
        tick();
        s_if.rdy = 1'b0;
        requester_done(e.port);
        chk("srd_gap", s_if.rd, 1'b0);
        chk("swr_gap", s_if.wr, 1'b0);
        chk("busy_gap", busy, 1'b1);
    endtask

    row_t tbl[7];

    initial begin
        int           r0, r1;
        int           k0, k1;
        logic [28:0]  a0, a1;
        logic [255:0] wd0, wd1, wd;
        logic [31:0]  mk0, mk1;
        logic         ord[9];

        tbl[0] = '{rd0:0, wr0:0, rd1:0, wr1:1, port:1, erd:0, ewr:1, eerr:0};
        tbl[1] = '{rd0:1, wr0:0, rd1:1, wr1:0, port:0, erd:1, ewr:0, eerr:0};
        tbl[2] = '{rd0:0, wr0:1, rd1:1, wr1:0, port:0, erd:0, ewr:1, eerr:0};
        tbl[3] = '{rd0:0, wr0:0, rd1:1, wr1:0, port:1, erd:1, ewr:0, eerr:0};
        tbl[4] = '{rd0:1, wr0:0, rd1:1, wr1:0, port:1, erd:1, ewr:0, eerr:0};
        tbl[5] = '{rd0:1, wr0:1, rd1:0, wr1:0, port:0, erd:1, ewr:0, eerr:1};
        tbl[6] = '{rd0:0, wr0:0, rd1:0, wr1:1, port:1, erd:0, ewr:1, eerr:1};

        reset = 1'b1;
        s_if.rdy = 1'b0;
        s_if.rdat = '0;
        drive(0, 1'b1, 1'b0, 29'h0012345, 256'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 29'h0, 256'h0, 32'h0);

        // Reset values with port 0 already requesting
        #2;
        chk("rst_srd", s_if.rd, 1'b0);
        chk("rst_swr", s_if.wr, 1'b0);
        chk("rst_sa", s_if.a, 29'h0);
        chk("rst_swdat", s_if.wdat, 256'h0);
        chk("rst_smsk", s_if.msk, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_owner", owner, 1'b1);
        chk("rst_proto_err", proto_err, 1'b0);
        chk("rst_m0_rdy", m0_if.rdy, 1'b0);
        chk("rst_m1_rdy", m1_if.rdy, 1'b0);
        tick();
        reset = 1'b0;
        rem[0] = 1;
        push(1'b0, 1'b1, 1'b0, 29'h0012345, 256'h0, 32'h0);
        serve(3, 1);

        // Port 1 masked write answered after 5 cycles
        wd = rnd256();
        drive(1, 1'b0, 1'b1, 29'h0ABCDE, wd, 32'h0000_00FF);
        rem[1] = 1;
        push(1'b1, 1'b0, 1'b1, 29'h0ABCDE, wd, 32'h0000_00FF);
        r0 = rdy0_cnt; r1 = rdy1_cnt;
        serve(5, 2);
        chk("wr_m1_rdy_pulses", rdy1_cnt - r1, 1);
        chk("wr_m0_rdy_pulses", rdy0_cnt - r0, 0);

        // Both ports streaming reads from reset: 0,0,0,0,1,1,1,1,0
        a0 = 29'h1000; a1 = 29'h2000; wd0 = rnd256(); wd1 = rnd256();
        drive(0, 1'b1, 1'b0, a0, wd0, 32'h0);
        drive(1, 1'b1, 1'b0, a1, wd1, 32'h0);
        rem[0] = 5; rem[1] = 4;
        ord = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        k0 = 0; k1 = 0;
        for (int i = 0; i < 9; i++) begin
            if (ord[i] == 1'b0) begin
                push(1'b0, 1'b1, 1'b0, a0 + 29'(k0), wd0 + 256'(k0), 32'h0);
                k0++;
            end else begin
                push(1'b1, 1'b1, 1'b0, a1 + 29'(k1), wd1 + 256'(k1), 32'h0);
                k1++;
            end
        end
        r0 = rdy0_cnt; r1 = rdy1_cnt;
        apply_reset();
        serve(3, 1);
        for (int i = 1; i < 9; i++) serve(3, 2);
        chk("rr_m0_completions", rdy0_cnt - r0, 5);
        chk("rr_m1_completions", rdy1_cnt - r1, 4);

        // Lone port 1: ten grants with no stall past the burst limit
        a1 = 29'h3000; wd1 = rnd256();
        drive(1, 1'b1, 1'b0, a1, wd1, 32'h0);
        rem[1] = 10;
        for (int i = 0; i < 10; i++) push(1'b1, 1'b1, 1'b0, a1 + 29'(i), wd1 + 256'(i), 32'h0);
        for (int i = 0; i < 10; i++) serve(2, 2);
        chk("solo_proto_err", proto_err, 1'b0);

        // Table of single transactions from reset
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            a0 = 29'h100 + 29'(i); a1 = 29'h200 + 29'(i);
            wd0 = rnd256(); wd1 = rnd256(); mk0 = $urandom; mk1 = $urandom;
            drive(0, tbl[i].rd0, tbl[i].wr0, a0, wd0, mk0);
            drive(1, tbl[i].rd1, tbl[i].wr1, a1, wd1, mk1);
            rem[0] = 1; rem[1] = 1;
            if (tbl[i].port == 1'b0) push(1'b0, tbl[i].erd, tbl[i].ewr, a0, wd0, mk0);
            else                     push(1'b1, tbl[i].erd, tbl[i].ewr, a1, wd1, mk1);
            serve(2, (i == 0) ? 1 : 2);
            chk("tbl_proto_err", proto_err, tbl[i].eerr);
            drive(0, 1'b0, 1'b0, a0, wd0, mk0);
            drive(1, 1'b0, 1'b0, a1, wd1, mk1);
        end

        // Spurious srdy in GAP
        apply_reset();
        chk("err_cleared", proto_err, 1'b0);
        drive(0, 1'b1, 1'b0, 29'h4000, 256'h0, 32'h0);
        rem[0] = 1;
        push(1'b0, 1'b1, 1'b0, 29'h4000, 256'h0, 32'h0);
        serve(2, 1);
        s_if.rdy = 1'b1;
        #1;
        chk("gap_srdy_m0", m0_if.rdy, 1'b0);
        chk("gap_srdy_m1", m1_if.rdy, 1'b0);
        tick();
        s_if.rdy = 1'b0;
        chk("gap_srdy_err", proto_err, 1'b1);

        // Spurious srdy in IDLE, then stickiness across a good transaction
        apply_reset();
        chk("err_cleared2", proto_err, 1'b0);
        s_if.rdy = 1'b1;
        #1;
        chk("idle_srdy_m0", m0_if.rdy, 1'b0);
        chk("idle_srdy_m1", m1_if.rdy, 1'b0);
        tick();
        s_if.rdy = 1'b0;
        chk("idle_srdy_err", proto_err, 1'b1);
        chk("idle_srdy_busy", busy, 1'b0);
        tick();
        tick();
        chk("err_sticky", proto_err, 1'b1);
        drive(1, 1'b1, 1'b0, 29'h5000, 256'h0, 32'h0);
        rem[1] = 1;
        push(1'b1, 1'b1, 1'b0, 29'h5000, 256'h0, 32'h0);
        serve(2, 1);
        chk("err_sticky_txn", proto_err, 1'b1);

        // Reset in the middle of ISSUE
        apply_reset();
        drive(0, 1'b1, 1'b0, 29'h6000, 256'h0, 32'h0);
        rem[0] = 1;
        tick();
        chk("pre_rst_srd", s_if.rd, 1'b1);
        chk("pre_rst_owner", owner, 1'b0);
        reset = 1'b1;
        #1;
        chk("mid_rst_srd", s_if.rd, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_owner", owner, 1'b1);
        tick();
        reset = 1'b0;
        push(1'b0, 1'b1, 1'b0, 29'h6000, 256'h0, 32'h0);
        serve(2, 1);

        if (sb.size() != 0) fail_now("scoreboard_leftover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/drac_arb.md
# drac_arb

Two-port arbiter sharing the single DDR3 controller user port (srd/swr/sa/swdat/smsk/srdat/srdy) between two requesters, e.g. the MicroBlaze glue adapter and a DMA/video engine. Sits in the ckdr (150 MHz) domain between the requesters and drac_ddr3. It:
- grants one transaction at a time, round-robin with a bounded same-owner burst;
- registers the downstream request;
- steers srdy back to the owner.

## Interface
- BURST, 4: max consecutive grants to one port while the other port is waiting (1..15).
- ckdr  in  1  controller clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- m0_rd, m0_wr  in  1  port 0 read/write request; held until m0_rdy.
- m0_a  in  [33:5]  port 0 32-byte line address.
- m0_wdat  in  256  port 0 write data.
- m0_msk  in  32  port 0 byte mask, 1 = byte not written.
- m0_rdat  out  256  read data; equals srdat.
- m0_rdy  out  1  one-cycle completion strobe for port 0.
- m1_rd, m1_wr, m1_a, m1_wdat, m1_msk, m1_rdat, m1_rdy: same as port 0, for port 1.
- srd, swr  out  1  registered request to drac_ddr3.
- sa  out  [33:5]  registered address.
- swdat  out  256  registered write data.
- smsk  out  32  registered mask.
- srdat  in  256  controller read data.
- srdy  in  1  controller completion strobe.
- busy  out  1  a transaction is outstanding.
- owner  out  1  port currently or last granted.
- proto_err  out  1  sticky protocol-violation flag; cleared only by reset.

## Operation
- Requester contract, both ports and downstream:
  - rd/wr, address, data and mask stay stable from assertion until the rdy cycle.
  - The requester may change or drop them from the edge that samples rdy.
- FSM states:
  - IDLE: pick a port from the current requests. At the edge, load sa/swdat/smsk from the winner, assert srd or swr, latch owner, go to ISSUE. No request: stay.
  - ISSUE: hold the downstream outputs. On srdy: clear srd/swr at the edge, go to GAP.
  - GAP: one dead cycle; requests ignored; go to IDLE.
- Pick rule:
  - Only one port requesting: grant it.
  - Both requesting: grant owner if cnt < BURST, else the other port.
- Burst counter cnt (4 bit):
  - Set to 1 on a grant to a new owner.
  - Incremented, saturating at 15, on a grant to the same owner.
  - Reset value cnt = BURST and owner = 1, so the first tie goes to port 0.
- Read data: mX_rdat = srdat, unconditionally.
- Completion strobe: mX_rdy = srdy & (state==ISSUE) & (owner==X), combinational.
- Boundary conditions:
  - rd and wr both high on the picked port: issue as a read; set proto_err.
  - srdy in IDLE or GAP: not forwarded to either port; set proto_err.
  - Reset mid-transaction: srd/swr drop immediately and the state returns to IDLE. drac_ddr3 shares the same reset, so no orphaned completion results.
  - A port that drops its request before its grant loses nothing. A port that drops its request while in ISSUE violates the contract; the arbiter keeps the transaction and completes it.

## Timing
- Reset values: srd=0, swr=0, sa=0, swdat=0, smsk=0, busy=0, owner=1, proto_err=0. m0_rdy and m1_rdy are 0 because the state is IDLE.
- Grant latency: a request first high in cycle N gives srd/swr high in cycle N+1, assuming IDLE in cycle N.
- Completion: mX_rdy is in the same cycle as srdy, zero latency. srd/swr are low in the following cycle.
- Back-to-back throughput: srdy in cycle K, GAP in K+1, IDLE pick in K+2, next srd/swr in K+3.
- busy = (state != IDLE).

## Structure
- Shared package/header drac_defs:
  - SA_MSB=33, SA_LSB=5, DW=256, MW=32;
  - FSM state encodings IDLE/ISSUE/GAP.
  - drac_ddr3 and the adapter reuse these.
- Sub-module drac_arb_pick: combinational 2-way pick from (req0, req1, owner, cnt, BURST). Outputs gnt_valid and gnt_port. Unit-testable alone.

## Test plan
- Reset with m0_rd=1 asserted → all outputs at reset values. First edge after reset release → srd=1, sa=m0_a, owner=0.
- m1_wr with m1_msk=32'h0000_00FF; srdy after 5 cycles → swdat/smsk match port 1 inputs. m1_rdy pulses once, in the srdy cycle. m0_rdy stays 0.
- Both ports continuously reading, BURST=4, controller answering in 3 cycles → grant order 0,0,0,0,1,1,1,1,0…. Each completion spaced by srdy + 3 cycles.
- Only port 1 requesting for 10 transactions → all 10 granted to port 1 with no stall, even when cnt exceeds BURST.
- srdy pulsed in IDLE; separately, m0_rd=m0_wr=1 → no rdy to either port on the spurious srdy; the m0 request is issued as a read; proto_err=1 and sticky until reset.
- Reset asserted mid-ISSUE → srd drops asynchronously, busy=0. After release, the pending requester is re-granted with 1-cycle latency.
